// File: rtl/mac_accumulator.sv
// -----------------------------------------------------------------------------
// mac_accumulator
//
// Accumulation stage downstream of the combinational multiplier in the MAC
// array. It sums ACC_LEN consecutive unsigned products into one dot-product
// result. The sum saturates to all-ones when ACC_WIDTH is too narrow. The
// result is held in an output register with its own valid/ready handshake.
//
// Parameters
//   WORD_SIZE  multiplier operand width; products are 2*WORD_SIZE bits
//   ACC_LEN    products per result (>= 2)
//   ACC_WIDTH  accumulator/result width
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous; drops the partial sum and the term count
//   in_valid   in   product is valid
//   in_ready   out  product is accepted this cycle (combinational)
//   product    in   unsigned product, 2*WORD_SIZE bits
//   out_valid  out  output register holds an unconsumed result
//   out_ready  in   downstream consumes the result this cycle
//   acc_out    out  accumulated result, ACC_WIDTH bits
//   out_sat    out  the result in acc_out was saturated
// -----------------------------------------------------------------------------
module mac_accumulator #(
  parameter int WORD_SIZE = 8,
  parameter int ACC_LEN   = 64,
  parameter int ACC_WIDTH = 22
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*WORD_SIZE-1:0] product,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   acc_out,
  output logic                   out_sat
);

  localparam int PROD_W = 2 * WORD_SIZE;
  localparam int CNT_W  = $clog2(ACC_LEN);
  // One bit wider than the larger operand, so the carry out is never lost.
  localparam int SUM_W  = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

  // Partial-sum state for the group in progress.
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_sat_acc;
  logic [CNT_W-1:0]     r_cnt;

  // Output register.
  logic [ACC_WIDTH-1:0] r_acc_out;
  logic                 r_out_sat;
  logic                 r_out_valid;

  logic                 w_last;
  logic                 w_accept;
  logic                 w_consume;
  logic [SUM_W-1:0]     w_sum;
  logic                 w_ovf;
  logic [ACC_WIDTH-1:0] w_clamped;

  assign w_last    = (r_cnt == LAST_CNT);

  // Only the final term of a group would overwrite a held result, so only
  // that term stalls; mid-group terms flow while the result waits.
  assign in_ready  = ~clear & ~(w_last & r_out_valid & ~out_ready);
  assign w_accept  = in_valid & in_ready;
  assign w_consume = r_out_valid & out_ready;

  assign w_sum     = SUM_W'(r_acc) + SUM_W'(product);
  assign w_ovf     = |w_sum[SUM_W-1:ACC_WIDTH];
  // Once saturated, r_acc is all-ones, so every later add overflows again
  // (or lands exactly on all-ones for a zero product): it stays pinned.
  assign w_clamped = w_ovf ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];

  // Partial sum, sticky saturation flag and term counter.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_sat_acc <= 1'b0;
      r_cnt     <= '0;
    end else if (clear) begin
      r_acc     <= '0;
      r_sat_acc <= 1'b0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_acc     <= '0;
        r_sat_acc <= 1'b0;
        r_cnt     <= '0;
      end else begin
        r_acc     <= w_clamped;
        r_sat_acc <= r_sat_acc | w_ovf;
        r_cnt     <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Output register. A final-term load takes priority over a consume, so a
  // simultaneous consume and load keeps out_valid high with the new result.
  // acc_out/out_sat keep their stale values after a plain consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_out   <= '0;
      r_out_sat   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept && w_last) begin
      r_acc_out   <= w_clamped;
      r_out_sat   <= r_sat_acc | w_ovf;
      r_out_valid <= 1'b1;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  assign acc_out   = r_acc_out;
  assign out_sat   = r_out_sat;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mac_accumulator.sv
// -----------------------------------------------------------------------------
// tb_mac_accumulator
//
// Directed bench for mac_accumulator with WORD_SIZE = 8 and ACC_LEN = 4.
// dut   : ACC_WIDTH = 18, driven by every phase.
// dut17 : ACC_WIDTH = 17. It shares the product bus and sees in_valid only
//         during the saturation phase.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mac_accumulator;

  localparam int WS  = 8;
  localparam int LEN = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clear;
  logic            in_valid;
  logic            in_ready;
  logic [2*WS-1:0] product;
  logic            out_valid;
  logic            out_ready;
  logic [17:0]     acc_out;
  logic            out_sat;

  logic            sat_phase;
  logic            in_valid_s;
  logic            in_ready_s;
  logic            out_valid_s;
  logic            out_ready_s;
  logic [16:0]     acc_out_s;
  logic            out_sat_s;

  int n_checks = 0;
  int n_errors = 0;
  int stalls;

  always #5 clk = ~clk;

  assign in_valid_s  = in_valid & sat_phase;
  assign out_ready_s = 1'b1;

  mac_accumulator #(.WORD_SIZE(WS), .ACC_LEN(LEN), .ACC_WIDTH(18)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .out_sat   (out_sat)
  );

  mac_accumulator #(.WORD_SIZE(WS), .ACC_LEN(LEN), .ACC_WIDTH(17)) dut17 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid_s),
    .in_ready  (in_ready_s),
    .product   (product),
    .out_valid (out_valid_s),
    .out_ready (out_ready_s),
    .acc_out   (acc_out_s),
    .out_sat   (out_sat_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one product and hold it until it is accepted (bounded wait).
  // Returns the number of stalled cycles before acceptance.
  task automatic accept_term(input logic [2*WS-1:0] p, output int n_stall);
    in_valid = 1'b1;
    product  = p;
    #1;
    n_stall = 0;
    while (!in_ready && n_stall < 20) begin
      tick();
      n_stall++;
    end
    if (n_stall >= 20) check("accept_timeout", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic term(input logic [2*WS-1:0] p);
    int s;
    accept_term(p, s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    product   = '0;
    out_ready = 1'b1;
    sat_phase = 1'b0;

    // Reset state.
    #1;
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_acc_out",   32'(acc_out),       32'd0);
    check("rst_out_sat",   {31'b0, out_sat},   32'd0);
    #11;
    rst_n = 1'b1;
    tick();

    // Basic group 1,2,3,4 then 5,5,5,5 back to back.
    term(16'd1); term(16'd2); term(16'd3); term(16'd4);
    check("basic_valid", {31'b0, out_valid}, 32'd1);
    check("basic_acc",   32'(acc_out),       32'd10);
    check("basic_sat",   {31'b0, out_sat},   32'd0);
    accept_term(16'd5, stalls);
    check("g2_t0_stall", 32'(stalls), 32'd0);
    check("basic_pulse", {31'b0, out_valid}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      accept_term(16'd5, stalls);
      check("g2_stall", 32'(stalls), 32'd0);
    end
    check("g2_valid", {31'b0, out_valid}, 32'd1);
    check("g2_acc",   32'(acc_out),       32'd20);
    tick();
    check("g2_consumed", {31'b0, out_valid}, 32'd0);
    check("g2_stale",    32'(acc_out),       32'd20);

    // Saturation: 4 x 65025 on both widths, then 1,1,1,1.
    sat_phase = 1'b1;
    for (int i = 0; i < 4; i++) term(16'd65025);
    check("sat18_acc",   32'(acc_out),         32'd260100);
    check("sat18_sat",   {31'b0, out_sat},     32'd0);
    check("sat17_valid", {31'b0, out_valid_s}, 32'd1);
    check("sat17_acc",   32'(acc_out_s),       32'd131071);
    check("sat17_sat",   {31'b0, out_sat_s},   32'd1);
    for (int i = 0; i < 4; i++) term(16'd1);
    check("sat17_next_acc", 32'(acc_out_s),     32'd4);
    check("sat17_next_sat", {31'b0, out_sat_s}, 32'd0);
    sat_phase = 1'b0;
    tick();

    // Backpressure.
    out_ready = 1'b0;
    term(16'd1); term(16'd2); term(16'd3); term(16'd4);
    check("bp_valid", {31'b0, out_valid}, 32'd1);
    check("bp_acc",   32'(acc_out),       32'd10);
    for (int i = 0; i < 3; i++) begin
      accept_term(16'd1, stalls);
      check("bp_mid_stall", 32'(stalls), 32'd0);
    end
    check("bp_hold_acc", 32'(acc_out), 32'd10);
    in_valid = 1'b1;
    product  = 16'd1;
    #1;
    check("bp_stall_ready", {31'b0, in_ready}, 32'd0);
    tick();
    tick();
    check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
    check("bp_hold_acc2",  32'(acc_out),       32'd10);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_new_valid", {31'b0, out_valid}, 32'd1);
    check("bp_new_acc",   32'(acc_out),       32'd4);
    out_ready = 1'b1;
    tick();
    check("bp_drained", {31'b0, out_valid}, 32'd0);

    // Clear mid-group with a product on the bus.
    term(16'd5); term(16'd6);
    clear    = 1'b1;
    in_valid = 1'b1;
    product  = 16'd9;
    #1;
    check("clr_ready", {31'b0, in_ready}, 32'd0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) term(16'd1);
    check("clr_valid", {31'b0, out_valid}, 32'd1);
    check("clr_acc",   32'(acc_out),       32'd4);

    // Bubbles: 7, gap, gap, 7, 7, gap, 7.
    term(16'd7);
    tick();
    tick();
    term(16'd7); term(16'd7);
    tick();
    check("bub_not_yet", {31'b0, out_valid}, 32'd0);
    term(16'd7);
    check("bub_valid", {31'b0, out_valid}, 32'd1);
    check("bub_acc",   32'(acc_out),       32'd28);
    tick();

    // Async reset mid-group while a result is held.
    out_ready = 1'b0;
    term(16'd3); term(16'd3); term(16'd3); term(16'd3);
    check("ar_pre_valid", {31'b0, out_valid}, 32'd1);
    check("ar_pre_acc",   32'(acc_out),       32'd12);
    term(16'd2); term(16'd2);
    rst_n = 1'b0;
    #2;
    check("ar_valid", {31'b0, out_valid}, 32'd0);
    check("ar_acc",   32'(acc_out),       32'd0);
    check("ar_sat",   {31'b0, out_sat},   32'd0);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) term(16'd2);
    check("ar_after_valid", {31'b0, out_valid}, 32'd1);
    check("ar_after_acc",   32'(acc_out),       32'd8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
